key_debounce_multi: RTL and testbench



---
 rtl/key_debounce_multi.sv | 104 ++++++++++
 tb/tb_key_debounce_multi.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: synchroniser, debounce filter, press/release pulses.
// Optional auto-repeat on held keys when KEY_REPEAT_EN is defined.
module key_debounce_multi #(
    parameter int N_KEYS        = 4,
    parameter int DEB_CYCLES    = 1000000,
    parameter int ACTIVE_LOW    = 1,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic              CLK,
    input  logic              Rstn,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_Level,
    output logic [N_KEYS-1:0] Key_Press,
    output logic [N_KEYS-1:0] Key_Release
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic IDLE = (ACTIVE_LOW != 0);

    if (DEB_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad
        $error("key_debounce_multi: cycle counts must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic          s1, s2;
        logic          p;
        logic          hit;
        logic          rpt;
        logic          lvl_q, prs_q, rel_q;
        logic [CW-1:0] cnt;

        assign p   = (ACTIVE_LOW != 0) ? ~s2 : s2;
        assign hit = (p != lvl_q) && (cnt == CNT_MAX);

        always_ff @(posedge CLK or negedge Rstn) begin
            if (!Rstn) begin
                s1 <= IDLE;
                s2 <= IDLE;
            end else begin
                s1 <= Key_In[i];
                s2 <= s1;
            end
        end

        always_ff @(posedge CLK or negedge Rstn) begin
            if (!Rstn) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
                prs_q <= 1'b0;
                rel_q <= 1'b0;
            end else begin
                prs_q <= (hit & p) | rpt;
                rel_q <= hit & ~p;
                if (p == lvl_q) begin
                    cnt <= '0;
                end else if (hit) begin
                    cnt   <= '0;
                    lvl_q <= p;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

`ifdef KEY_REPEAT_EN
        localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                              HOLD_CYCLES : REPEAT_CYCLES;
        localparam int HW = (HMAX > 1) ? $clog2(HMAX) : 1;
        localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
        localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_CYCLES - 1);

        logic [HW-1:0] hold;
        logic          rep;

        // An accepted release outranks a repeat due on the same edge.
        assign rpt = lvl_q && !hit &&
                     (rep ? (hold == REP_MAX) : (hold == HOLD_MAX));

        always_ff @(posedge CLK or negedge Rstn) begin
            if (!Rstn) begin
                hold <= '0;
                rep  <= 1'b0;
            end else if (!lvl_q || hit) begin
                hold <= '0;
                rep  <= 1'b0;
            end else if (rpt) begin
                hold <= '0;
                rep  <= 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
`else
        assign rpt = 1'b0;
`endif

        assign Key_Level[i]   = lvl_q;
        assign Key_Press[i]   = prs_q;
        assign Key_Release[i] = rel_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: table of per-edge vectors plus
// hand-written reset, DEB_CYCLES=1 and hold/auto-repeat sequences.
module tb_key_debounce_multi;

    logic       CLK;
    logic       Rstn;
    logic [1:0] ka, kb;
    logic [1:0] lvl_a, prs_a, rel_a;
    logic [1:0] lvl_b, prs_b, rel_b;

    int checks = 0;
    int errors = 0;

`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    key_debounce_multi #(
        .N_KEYS(2), .DEB_CYCLES(8), .ACTIVE_LOW(1),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_a (
        .CLK(CLK), .Rstn(Rstn), .Key_In(ka),
        .Key_Level(lvl_a), .Key_Press(prs_a), .Key_Release(rel_a)
    );

    key_debounce_multi #(
        .N_KEYS(2), .DEB_CYCLES(1), .ACTIVE_LOW(0),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_b (
        .CLK(CLK), .Rstn(Rstn), .Key_In(kb),
        .Key_Level(lvl_b), .Key_Press(prs_b), .Key_Release(rel_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0] key;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [1:0] k, input logic [1:0] l,
                                input logic [1:0] p, input logic [1:0] r);
        vec_t v;
        v.key = k; v.lvl = l; v.prs = p; v.rel = r;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk3a(input string nm, input logic [1:0] l,
                         input logic [1:0] p, input logic [1:0] r);
        chk({nm, " lvl"}, lvl_a, l);
        chk({nm, " prs"}, prs_a, p);
        chk({nm, " rel"}, rel_a, r);
    endtask

    task automatic step(input logic [1:0] a, input logic [1:0] b,
                        input logic r);
        @(negedge CLK);
        ka = a; kb = b; Rstn = r;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [1:0] pb[4];
        logic [1:0] prev, ep, el, er;

        // press ch0 (latency 9 edges)
        for (int i = 0; i < 9; i++) add(2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b10, 2'b01, 2'b01, 2'b00);
        add(2'b10, 2'b01, 2'b00, 2'b00);
        add(2'b10, 2'b01, 2'b00, 2'b00);
        // release ch0
        for (int i = 0; i < 9; i++) add(2'b11, 2'b01, 2'b00, 2'b00);
        add(2'b11, 2'b00, 2'b00, 2'b01);
        add(2'b11, 2'b00, 2'b00, 2'b00);
        // 5-cycle bounce on ch0 is rejected
        for (int i = 0; i < 5; i++) add(2'b10, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 12; i++) add(2'b11, 2'b00, 2'b00, 2'b00);
        // both channels together
        for (int i = 0; i < 9; i++) add(2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2'b11, 2'b11, 2'b00);
        add(2'b00, 2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 9; i++) add(2'b11, 2'b11, 2'b00, 2'b00);
        add(2'b11, 2'b00, 2'b00, 2'b11);
        add(2'b11, 2'b00, 2'b00, 2'b00);

        Rstn = 1'b0; ka = 2'b11; kb = 2'b00;
        repeat (3) @(negedge CLK);
        #1;
        chk3a("reset a", 2'b00, 2'b00, 2'b00);
        chk("reset b lvl", lvl_b, 2'b00);
        chk("reset b prs", prs_b, 2'b00);
        chk("reset b rel", rel_b, 2'b00);

        // DEB_CYCLES=1, active-high: accepted 2 edges after sampling
        pb[0] = 2'b10; pb[1] = 2'b00; pb[2] = 2'b11; pb[3] = 2'b00;
        prev = 2'b00;
        for (int j = 0; j < 4; j++) begin
            for (int e = 0; e < 4; e++) begin
                step(2'b11, pb[j], 1'b1);
                el = (e >= 2) ? pb[j] : prev;
                ep = (e == 2) ? (pb[j] & ~prev) : 2'b00;
                er = (e == 2) ? (prev & ~pb[j]) : 2'b00;
                chk("deb1 lvl", lvl_b, el);
                chk("deb1 prs", prs_b, ep);
                chk("deb1 rel", rel_b, er);
            end
            prev = pb[j];
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].key, 2'b00, 1'b1);
            chk3a($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel);
        end

        // ch1 pressed, ch0 mid-count (cnt=4), then reset
        for (int e = 0; e < 10; e++) step(2'b01, 2'b00, 1'b1);
        chk3a("ch1 held", 2'b10, 2'b10, 2'b00);
        for (int e = 0; e < 6; e++) step(2'b00, 2'b00, 1'b1);
        chk3a("mid count", 2'b10, 2'b00, 2'b00);
        for (int e = 0; e < 3; e++) begin
            step(2'b00, 2'b00, 1'b0);
            chk3a("in reset", 2'b00, 2'b00, 2'b00);
        end
        for (int e = 0; e < 12; e++) begin
            step(2'b00, 2'b00, 1'b1);
            chk3a("after reset", (e >= 9) ? 2'b11 : 2'b00,
                  (e == 9) ? 2'b11 : 2'b00, 2'b00);
        end
        for (int e = 0; e < 11; e++) begin
            step(2'b11, 2'b00, 1'b1);
            chk3a("release both", (e < 9) ? 2'b11 : 2'b00, 2'b00,
                  (e == 9) ? 2'b11 : 2'b00);
        end

        // long hold on ch0; release sampled at edge 70, accepted at 79
        for (int e = 0; e < 91; e++) begin
            step((e < 70) ? 2'b10 : 2'b11, 2'b00, 1'b1);
            ep = (e == 9 || (REP_EN && e >= 29 && e < 79 &&
                  (e - 29) % 5 == 0)) ? 2'b01 : 2'b00;
            el = (e >= 9 && e < 79) ? 2'b01 : 2'b00;
            er = (e == 79) ? 2'b01 : 2'b00;
            chk3a($sformatf("hold e%0d", e), el, ep, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
